restoring_div_32: RTL

- Sequential restoring divider. It is the inverse companion of the combinational wallace multipliers: it computes quotient and remainder of unsigned WIDTH-bit operands, one quotient bit per clock.
- Sits beside the multiplier hierarchy. Verification closes the loop by checking Q*B + R == A through the existing 32-bit multiplier path.
- Valid/ready handshakes on input and output. One division in flight at a time.

---
 rtl/div_pkg.sv | 34 +++
 rtl/div_step.sv | 40 ++++
 rtl/restoring_div_32.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   - div_state_t      : controller states (IDLE, CALC, DONE)
//   - DIV_WIDTH_DEFAULT: default operand width
//   - dbz_quotient()   : quotient pattern returned for a zero divisor
// No ports (package).
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // Widest operand the divide-by-zero pattern helper supports.
    localparam int DIV_WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // All-ones quotient of the requested width, returned when B == 0.
    function automatic logic [DIV_WIDTH_MAX-1:0] dbz_quotient(input int width);
        logic [DIV_WIDTH_MAX-1:0] mask;
        mask = '0;
        for (int i = 0; i < DIV_WIDTH_MAX; i++) begin
            if (i < width) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
// Ports:
//   rem      (in,  WIDTH) partial remainder, always < divisor
//   next_bit (in,  1)     next dividend bit shifted into the remainder
//   divisor  (in,  WIDTH) divisor B
//   rem_next (out, WIDTH) updated partial remainder
//   q_bit    (out, 1)     quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // The shifted remainder needs WIDTH+1 bits because rem may have its MSB
    // set when the divisor is large; the trial difference carries one more
    // bit so the borrow is explicit.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    assign shifted = {rem, next_bit};
    assign trial   = {1'b0, shifted} - {2'b00, divisor};

    // Non-negative trial: no borrow, and the result is below the divisor so
    // bit WIDTH is clear as well.
    assign q_bit    = (trial[WIDTH+1:WIDTH] == 2'b00);

    // Restore: when the trial went negative, shifted < divisor, so its low
    // WIDTH bits are the exact new remainder.
    assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/restoring_div_32.sv
// -----------------------------------------------------------------------------
// restoring_div_32
// Sequential restoring divider: Q = A / B, R = A % B, one quotient bit per
// clock, valid/ready on both sides, one operation in flight.
// Optional macro DIV_SIGNED_EN: two's-complement operands with truncating
// division; adds one sign fix-up cycle before the result is presented.
// Ports:
//   clk         (in)         rising-edge clock
//   rst_n       (in)         asynchronous active-low reset
//   in_valid    (in)         dividend/divisor valid
//   in_ready    (out)        block can accept an operation
//   dividend    (in,  WIDTH) A
//   divisor     (in,  WIDTH) B
//   out_valid   (out)        result valid
//   out_ready   (in)         consumer accepts result
//   quotient    (out, WIDTH) Q
//   remainder   (out, WIDTH) R
//   div_by_zero (out)        set with the result when B == 0
// -----------------------------------------------------------------------------
module restoring_div_32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] DBZ_QUOTIENT = WIDTH'(dbz_quotient(WIDTH));

    div_state_t       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] aq_reg;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;
    logic             out_valid_reg;
    logic             in_ready_reg;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] step_aq;
    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign accept    = in_valid && in_ready_reg && (state_reg == IDLE);
    assign last_step = (count_reg == CNT_W'(1));
    assign step_aq   = {aq_reg[WIDTH-2:0], step_q};

`ifdef DIV_SIGNED_EN
    logic neg_q_reg;
    logic neg_r_reg;
    logic fix_reg;     // DONE entered, sign correction still pending
    logic a_neg;
    logic b_neg;

    assign a_neg = dividend[WIDTH-1];
    assign b_neg = divisor[WIDTH-1];
    // -2^(W-1) maps to itself, which is the correct unsigned magnitude.
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor  : divisor;
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_reg),
        .next_bit(aq_reg[WIDTH-1]),
        .divisor (b_reg),
        .rem_next(step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            aq_reg        <= '0;
            b_reg         <= '0;
            rem_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
`ifdef DIV_SIGNED_EN
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            fix_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        in_ready_reg <= 1'b0;
                        rem_reg      <= '0;
                        count_reg    <= CNT_W'(WIDTH);
                        aq_reg       <= a_mag;
                        b_reg        <= b_mag;
                        if (divisor == '0) begin
                            // Zero divisor skips the iterations entirely and
                            // reports the raw dividend as remainder.
                            state_reg     <= DONE;
                            quotient_reg  <= DBZ_QUOTIENT;
                            remainder_reg <= dividend;
                            dbz_reg       <= 1'b1;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= CALC;
                            dbz_reg   <= 1'b0;
`ifdef DIV_SIGNED_EN
                            neg_q_reg <= a_neg ^ b_neg;
                            neg_r_reg <= a_neg;
`endif
                        end
                    end
                end

                CALC: begin
                    aq_reg    <= step_aq;
                    rem_reg   <= step_rem;
                    count_reg <= count_reg - CNT_W'(1);
                    if (last_step) begin
                        state_reg     <= DONE;
                        quotient_reg  <= step_aq;
                        remainder_reg <= step_rem;
`ifdef DIV_SIGNED_EN
                        fix_reg       <= 1'b1;
`else
                        out_valid_reg <= 1'b1;
`endif
                    end
                end

                DONE: begin
`ifdef DIV_SIGNED_EN
                    if (fix_reg) begin
                        fix_reg       <= 1'b0;
                        out_valid_reg <= 1'b1;
                        quotient_reg  <= neg_q_reg ? -quotient_reg  : quotient_reg;
                        remainder_reg <= neg_r_reg ? -remainder_reg : remainder_reg;
                    end else if (out_ready) begin
`else
                    if (out_ready) begin
`endif
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule
